// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master with start/busy/done handshake.
// SCLK is a registered output generated from the system clock.
module spi_master_param #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned CLK_DIV   = 4,
  parameter bit          CPOL      = 1'b0,
  parameter bit          CPHA      = 1'b0,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  input  logic              miso,
  output logic              mosi,
  output logic              sclk,
  output logic              cs_n
);

  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned EDGE_W = $clog2(2 * DATA_W);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);

  typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_e;

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [EDGE_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic [DATA_W-1:0]   tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0]   rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic                cs_n_q, cs_n_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                tick;
  logic                tx_head;
  logic                tx_data_head;
  logic                sample_edge;

  assign tick         = (div_cnt_q == DIV_LAST);
  assign tx_head      = MSB_FIRST ? tx_sh_q[DATA_W-1] : tx_sh_q[0];
  assign tx_data_head = MSB_FIRST ? tx_data[DATA_W-1] : tx_data[0];
  // Even edge_cnt is a leading edge; CPHA=0 samples there, CPHA=1 on the odd ones.
  assign sample_edge  = (~edge_cnt_q[0]) ^ CPHA;

  // Next-state and output computation for the transfer sequencer.
  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    edge_cnt_d = edge_cnt_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = LEAD;
          cs_n_d     = 1'b0;
          busy_d     = 1'b1;
          div_cnt_d  = '0;
          edge_cnt_d = '0;
          rx_sh_d    = '0;
          if (!CPHA) begin
            // First bit goes out with CS; the register keeps only what remains.
            mosi_d  = tx_data_head;
            tx_sh_d = MSB_FIRST ? {tx_data[DATA_W-2:0], 1'b0}
                                : {1'b0, tx_data[DATA_W-1:1]};
          end else begin
            mosi_d  = 1'b0;
            tx_sh_d = tx_data;
          end
        end
      end
      LEAD: begin
        if (tick) begin
          div_cnt_d = '0;
          state_d   = XFER;
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      XFER: begin
        if (tick) begin
          div_cnt_d  = '0;
          sclk_d     = ~sclk_q;
          edge_cnt_d = edge_cnt_q + EDGE_W'(1);
          if (sample_edge) begin
            rx_sh_d = MSB_FIRST ? {rx_sh_q[DATA_W-2:0], miso}
                                : {miso, rx_sh_q[DATA_W-1:1]};
          end else if (CPHA || (edge_cnt_q != EDGE_LAST)) begin
            mosi_d  = tx_head;
            tx_sh_d = MSB_FIRST ? {tx_sh_q[DATA_W-2:0], 1'b0}
                                : {1'b0, tx_sh_q[DATA_W-1:1]};
          end
          if (edge_cnt_q == EDGE_LAST) begin
            edge_cnt_d = '0;
            state_d    = TRAIL;
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      TRAIL: begin
        if (tick) begin
          div_cnt_d = '0;
          state_d   = IDLE;
          cs_n_d    = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          rx_data_d = rx_sh_q;
          mosi_d    = 1'b0;
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      div_cnt_q  <= '0;
      edge_cnt_q <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      sclk_q     <= CPOL;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;
  assign mosi    = mosi_q;
  assign sclk    = sclk_q;
  assign cs_n    = cs_n_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param: three configurations sharing one clock.
module tb_spi_master_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // A: defaults (mode 0, 8 bit, div 4, MSB first), loopback
  logic        a_start = 1'b0, a_busy, a_done, a_mosi, a_sclk, a_cs_n, a_miso;
  logic [7:0]  a_tx = '0, a_rx;
  // B: CPOL=1 CPHA=1, slave model drives 8'hC3
  logic        b_start = 1'b0, b_busy, b_done, b_mosi, b_sclk, b_cs_n;
  logic        b_miso = 1'b0;
  logic [7:0]  b_tx = '0, b_rx;
  // C: 16 bit, div 2, LSB first, loopback
  logic        c_start = 1'b0, c_busy, c_done, c_mosi, c_sclk, c_cs_n, c_miso;
  logic [15:0] c_tx = '0, c_rx;

  assign a_miso = a_mosi;
  assign c_miso = c_mosi;

  spi_master_param #(.DATA_W(8), .CLK_DIV(4), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .tx_data(a_tx), .busy(a_busy), .done(a_done),
    .rx_data(a_rx), .miso(a_miso), .mosi(a_mosi), .sclk(a_sclk), .cs_n(a_cs_n));

  spi_master_param #(.DATA_W(8), .CLK_DIV(4), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b1)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .tx_data(b_tx), .busy(b_busy), .done(b_done),
    .rx_data(b_rx), .miso(b_miso), .mosi(b_mosi), .sclk(b_sclk), .cs_n(b_cs_n));

  spi_master_param #(.DATA_W(16), .CLK_DIV(2), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b0)) u_c (
    .clk(clk), .rst(rst), .start(c_start), .tx_data(c_tx), .busy(c_busy), .done(c_done),
    .rx_data(c_rx), .miso(c_miso), .mosi(c_mosi), .sclk(c_sclk), .cs_n(c_cs_n));

  // Per-instance observation: CS length/gap, MOSI at rising SCLK, done bookkeeping.
  int a_cs_cnt = 0, a_cs_len = 0, a_hi = 0, a_gap = 0, a_rises = 0, a_glitch = 0;
  int a_done_cnt = 0, a_overlap = 0;
  logic a_bfall = 1'b0, a_pcs = 1'b1, a_psclk = 1'b0, a_pmosi = 1'b0, a_pbusy = 1'b0;
  logic [15:0] a_bits = '0;

  int b_rises = 0, b_glitch = 0, b_overlap = 0;
  logic b_pcs = 1'b1, b_psclk = 1'b1, b_pmosi = 1'b0;
  logic [15:0] b_bits = '0;
  logic [7:0]  b_slave = '0;

  int c_cs_cnt = 0, c_cs_len = 0, c_rises = 0, c_overlap = 0;
  logic c_pcs = 1'b1, c_psclk = 1'b0;
  logic [15:0] c_bits = '0;

  always @(negedge clk) begin
    if (!a_cs_n && a_pcs) begin
      a_cs_cnt = 0; a_rises = 0; a_bits = '0; a_glitch = 0; a_gap = a_hi;
    end
    if (a_cs_n) a_hi = a_pcs ? a_hi + 1 : 1;
    if (!a_cs_n) a_cs_cnt++;
    if (a_cs_n && !a_pcs) a_cs_len = a_cs_cnt;
    if (a_sclk && !a_psclk) begin
      a_rises++;
      a_bits = {a_bits[14:0], a_mosi};
      if (a_mosi !== a_pmosi) a_glitch++;
    end
    if (a_done) begin
      a_done_cnt++;
      a_bfall = a_pbusy && !a_busy;
      if (a_busy) a_overlap++;
    end
    a_pcs = a_cs_n; a_psclk = a_sclk; a_pmosi = a_mosi; a_pbusy = a_busy;
  end

  always @(negedge clk) begin
    if (!b_cs_n && b_pcs) begin
      b_rises = 0; b_bits = '0; b_glitch = 0; b_slave = 8'hC3;
    end
    if (!b_sclk && b_psclk && !b_cs_n) begin
      b_miso  = b_slave[7];
      b_slave = {b_slave[6:0], 1'b0};
    end
    if (b_sclk && !b_psclk) begin
      b_rises++;
      b_bits = {b_bits[14:0], b_mosi};
      if (b_mosi !== b_pmosi) b_glitch++;
    end
    if (b_done && b_busy) b_overlap++;
    b_pcs = b_cs_n; b_psclk = b_sclk; b_pmosi = b_mosi;
  end

  always @(negedge clk) begin
    if (!c_cs_n && c_pcs) begin
      c_cs_cnt = 0; c_rises = 0; c_bits = '0;
    end
    if (!c_cs_n) c_cs_cnt++;
    if (c_cs_n && !c_pcs) c_cs_len = c_cs_cnt;
    if (c_sclk && !c_psclk) begin
      c_rises++;
      c_bits = {c_bits[14:0], c_mosi};
    end
    if (c_done && c_busy) c_overlap++;
    c_pcs = c_cs_n; c_psclk = c_sclk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Steps land 1 time unit after the falling edge, after the monitors have run.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input int which, input int maxc, input string tag);
    for (int i = 0; i < maxc; i++) begin
      step(1);
      if ((which == 0 && a_done) || (which == 1 && b_done) || (which == 2 && c_done)) return;
    end
    checks++;
    failures++;
    $display("FAIL %s timeout observed=no_done required=done_within_%0d", tag, maxc);
  endtask

  int done_before;

  initial begin
    // Reset state
    step(3);
    check("rst_a_cs_n", 32'(a_cs_n), 32'h1);
    check("rst_a_sclk", 32'(a_sclk), 32'h0);
    check("rst_a_mosi", 32'(a_mosi), 32'h0);
    check("rst_a_busy", 32'(a_busy), 32'h0);
    check("rst_a_done", 32'(a_done), 32'h0);
    check("rst_a_rx",   32'(a_rx),   32'h0);
    check("rst_b_sclk", 32'(b_sclk), 32'h1);
    check("rst_c_rx",   32'(c_rx),   32'h0);
    rst = 1'b0;
    step(2);

    // Mode 0, A5 loopback
    a_tx = 8'hA5; a_start = 1'b1;
    step(1);
    a_start = 1'b0; a_tx = 8'h00;
    check("m0_busy_after_accept", 32'(a_busy), 32'h1);
    check("m0_cs_low",            32'(a_cs_n), 32'h0);
    wait_done(0, 200, "m0_done");
    check("m0_busy_at_done", 32'(a_busy), 32'h0);
    check("m0_rx",           32'(a_rx),   32'hA5);
    step(1);
    check("m0_mosi_bits",   32'(a_bits[7:0]), 32'hA5);
    check("m0_rises",       32'(a_rises),     32'd8);
    check("m0_mosi_stable", 32'(a_glitch),    32'd0);
    check("m0_cs_len",      32'(a_cs_len),    32'd72);
    check("m0_busy_fall",   32'(a_bfall),     32'h1);
    check("m0_mosi_idle",   32'(a_mosi),      32'h0);

    // CPOL=1 CPHA=1, 3C out, slave returns C3
    b_tx = 8'h3C; b_start = 1'b1;
    step(1);
    b_start = 1'b0;
    check("m3_sclk_idle_lead", 32'(b_sclk), 32'h1);
    wait_done(1, 200, "m3_done");
    check("m3_rx", 32'(b_rx), 32'hC3);
    step(1);
    check("m3_mosi_bits",      32'(b_bits[7:0]), 32'h3C);
    check("m3_rises",          32'(b_rises),     32'd8);
    check("m3_mosi_on_fall",   32'(b_glitch),    32'd0);
    check("m3_sclk_idle_end",  32'(b_sclk),      32'h1);

    // 16 bit, div 2, LSB first, 8001 loopback; (2*16+2)*2 = 68 cycles of CS low
    c_tx = 16'h8001; c_start = 1'b1;
    step(1);
    c_start = 1'b0;
    wait_done(2, 200, "w16_done");
    check("w16_rx", 32'(c_rx), 32'h8001);
    step(1);
    check("w16_first_bit", 32'(c_bits[15]), 32'h1);
    check("w16_last_bit",  32'(c_bits[0]),  32'h1);
    check("w16_mosi_bits", 32'(c_bits),     32'h8001);
    check("w16_rises",     32'(c_rises),    32'd16);
    check("w16_cs_len",    32'(c_cs_len),   32'd68);

    // start pulsed mid-transfer with another word: ignored
    done_before = a_done_cnt;
    a_tx = 8'h3C; a_start = 1'b1;
    step(1);
    a_start = 1'b0;
    step(20);
    a_tx = 8'hFF; a_start = 1'b1;
    step(1);
    a_start = 1'b0;
    wait_done(0, 200, "mid_done");
    check("mid_rx", 32'(a_rx), 32'h3C);
    step(150);
    check("mid_done_count", 32'(a_done_cnt - done_before), 32'd1);
    check("mid_rx_held",    32'(a_rx),                     32'h3C);
    check("mid_idle",       32'(a_cs_n),                   32'h1);

    // Back-to-back, start held through done
    a_tx = 8'h5A; a_start = 1'b1;
    wait_done(0, 200, "b2b_done1");
    check("b2b_rx1", 32'(a_rx), 32'h5A);
    a_tx = 8'hFF;
    step(1);
    check("b2b_second_accepted", 32'(a_busy), 32'h1);
    a_start = 1'b0;
    wait_done(0, 200, "b2b_done2");
    check("b2b_rx2", 32'(a_rx), 32'hFF);
    check("b2b_gap", 32'(a_gap), 32'd1);
    step(1);
    check("b2b_cs_len2", 32'(a_cs_len), 32'd72);

    // Asynchronous reset at edge_cnt=7
    done_before = a_done_cnt;
    a_tx = 8'hA5; a_start = 1'b1;
    step(1);
    a_start = 1'b0;
    for (int i = 0; i < 200 && a_rises < 4; i++) step(1);
    check("rst_mid_reached", 32'(a_rises), 32'd4);
    check("rst_mid_cs_before", 32'(a_cs_n), 32'h0);
    rst = 1'b1;
    #1;
    check("rst_mid_cs_n", 32'(a_cs_n), 32'h1);
    check("rst_mid_sclk", 32'(a_sclk), 32'h0);
    check("rst_mid_mosi", 32'(a_mosi), 32'h0);
    check("rst_mid_busy", 32'(a_busy), 32'h0);
    step(2);
    rst = 1'b0;
    step(100);
    check("rst_mid_no_done", 32'(a_done_cnt - done_before), 32'd0);
    check("rst_mid_rx_cleared", 32'(a_rx), 32'h0);
    a_tx = 8'hA5; a_start = 1'b1;
    step(1);
    a_start = 1'b0;
    wait_done(0, 200, "rst_clean_done");
    check("rst_clean_rx", 32'(a_rx), 32'hA5);
    step(1);
    check("rst_clean_cs_len", 32'(a_cs_len), 32'd72);
    check("rst_clean_rises",  32'(a_rises),  32'd8);

    check("a_done_while_busy", 32'(a_overlap), 32'd0);
    check("b_done_while_busy", 32'(b_overlap), 32'd0);
    check("c_done_while_busy", 32'(c_overlap), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
